// File: rtl/ace_dispatch_credit.sv
// ace_dispatch_credit: in-order dispatch gating against ROB/RS0/RS1/LDQ/STQ credit, with registered occupancy tracking.
module ace_dispatch_credit #(
  parameter int DISP_W    = 4,
  parameter int ROB_DEPTH = 32,
  parameter int RS0_DEPTH = 16,
  parameter int RS1_DEPTH = 16,
  parameter int LDQ_DEPTH = 8,
  parameter int STQ_DEPTH = 8
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               stall_i,
  input  logic                               flush_i,
  input  logic [DISP_W-1:0]                  rename_vld_i,
  input  logic [DISP_W-1:0]                  rename_rs0_i,
  input  logic [DISP_W-1:0]                  rename_rs1_i,
  input  logic [DISP_W-1:0]                  rename_ld_i,
  input  logic [DISP_W-1:0]                  rename_st_i,
  input  logic [$clog2(DISP_W+1)-1:0]        rob_rel_i,
  input  logic [$clog2(DISP_W+1)-1:0]        rs0_rel_i,
  input  logic [$clog2(DISP_W+1)-1:0]        rs1_rel_i,
  input  logic [$clog2(DISP_W+1)-1:0]        ldq_rel_i,
  input  logic [$clog2(DISP_W+1)-1:0]        stq_rel_i,
  output logic [DISP_W-1:0]                  dispatch_grant_o,
  output logic                               dispatch_frontend_stl_o,
  output logic [$clog2(ROB_DEPTH+1)-1:0]     dispatch_rob_occ_o,
  output logic [$clog2(RS0_DEPTH+1)-1:0]     dispatch_rs0_occ_o,
  output logic [$clog2(RS1_DEPTH+1)-1:0]     dispatch_rs1_occ_o,
  output logic [$clog2(LDQ_DEPTH+1)-1:0]     dispatch_ldq_occ_o,
  output logic [$clog2(STQ_DEPTH+1)-1:0]     dispatch_stq_occ_o,
  output logic                               dispatch_err_o
);
  localparam int CW = $clog2(DISP_W+1);
  localparam int DEP [5] = '{ROB_DEPTH, RS0_DEPTH, RS1_DEPTH, LDQ_DEPTH, STQ_DEPTH};
  localparam int M01 = ROB_DEPTH > RS0_DEPTH ? ROB_DEPTH : RS0_DEPTH;
  localparam int M23 = RS1_DEPTH > LDQ_DEPTH ? RS1_DEPTH : LDQ_DEPTH;
  localparam int M03 = M01 > M23 ? M01 : M23;
  localparam int MX  = M03 > STQ_DEPTH ? M03 : STQ_DEPTH;
  localparam int OM  = $clog2(MX+1);
  logic [OM-1:0] occ [5];
  logic [OM-1:0] nxt [5];
  logic [CW-1:0] rel [5];
  logic [OM:0]   cum [5];
  logic [OM:0]   tot [5];
  logic [OM:0]   sum [5];
  logic [4:0]    und;
  logic          go, fit;
  assign rel = '{rob_rel_i, rs0_rel_i, rs1_rel_i, ldq_rel_i, stq_rel_i};
  // Walk slots oldest first; the first valid slot that does not fit closes the window.
  always_comb begin
    go = ~stall_i & ~flush_i;
    fit = 1'b0;
    dispatch_grant_o = '0;
    for (int q = 0; q < 5; q++) begin
      cum[q] = '0;
      tot[q] = '0;
      sum[q] = '0;
      nxt[q] = '0;
    end
    und = '0;
    for (int i = 0; i < DISP_W; i++) begin
      tot[0] = cum[0] + (OM+1)'(1);
      tot[1] = cum[1] + (OM+1)'(rename_rs0_i[i]);
      tot[2] = cum[2] + (OM+1)'(rename_rs1_i[i]);
      tot[3] = cum[3] + (OM+1)'(rename_ld_i[i]);
      tot[4] = cum[4] + (OM+1)'(rename_st_i[i]);
      fit = 1'b1;
      for (int q = 0; q < 5; q++)
        fit = fit & (tot[q] <= (OM+1)'(DEP[q]) - {1'b0, occ[q]});
      if (rename_vld_i[i] && go) begin
        if (fit) begin
          dispatch_grant_o[i] = 1'b1;
          for (int q = 0; q < 5; q++) cum[q] = tot[q];
        end else go = 1'b0;
      end
    end
    for (int q = 0; q < 5; q++) begin
      sum[q] = cum[q] + {1'b0, occ[q]};
      und[q] = (OM+1)'(rel[q]) > sum[q];
      nxt[q] = und[q] ? '0 : OM'(sum[q] - (OM+1)'(rel[q]));
    end
  end
  assign dispatch_frontend_stl_o = |(rename_vld_i & ~dispatch_grant_o);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int q = 0; q < 5; q++) occ[q] <= '0;
      dispatch_err_o <= 1'b0;
    end else if (flush_i) begin
      for (int q = 0; q < 5; q++) occ[q] <= '0;
    end else begin
      for (int q = 0; q < 5; q++) occ[q] <= nxt[q];
      if (|und) dispatch_err_o <= 1'b1;
    end
  end
  assign dispatch_rob_occ_o = $bits(dispatch_rob_occ_o)'(occ[0]);
  assign dispatch_rs0_occ_o = $bits(dispatch_rs0_occ_o)'(occ[1]);
  assign dispatch_rs1_occ_o = $bits(dispatch_rs1_occ_o)'(occ[2]);
  assign dispatch_ldq_occ_o = $bits(dispatch_ldq_occ_o)'(occ[3]);
  assign dispatch_stq_occ_o = $bits(dispatch_stq_occ_o)'(occ[4]);
endmodule
